// File: rtl/rtr_route_queue.sv
// Per-input-port route queue: drives the routing logic on head flits and keeps
// a 2-deep queue of computed routes per VC, retiring the front route on tail departure.
module rtr_route_queue #(
  parameter int num_message_classes  = 2,
  parameter int num_resource_classes = 2,
  parameter int num_vcs_per_class    = 1,
  parameter int num_ports            = 5,
  parameter int dest_info_width      = 8,
  localparam int num_vcs = num_message_classes * num_resource_classes * num_vcs_per_class
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     flit_valid_in,
  input  logic                                     flit_head_in,
  input  logic                                     flit_tail_in,
  input  logic [num_vcs-1:0]                       flit_sel_ivc_in,
  input  logic [dest_info_width-1:0]               flit_dest_info_in,
  output logic [dest_info_width-1:0]               rl_dest_info,
  output logic [num_message_classes-1:0]           rl_sel_mc,
  output logic [num_resource_classes-1:0]          rl_sel_irc,
  input  logic [num_ports-1:0]                     rl_route_op,
  input  logic [num_resource_classes-1:0]          rl_route_orc,
  input  logic [num_vcs-1:0]                       flit_dep_ivc,
  input  logic                                     flit_dep_tail,
  output logic [num_vcs-1:0]                       route_valid_ivc,
  output logic [num_vcs*num_ports-1:0]             route_ivc_op,
  output logic [num_vcs*num_resource_classes-1:0]  route_ivc_orc,
  output logic [num_vcs-1:0]                       error_ivc
);

  assign rl_dest_info = flit_dest_info_in;

  // VC index is mc-major, then rc, then vc within the class.
  always_comb begin
    rl_sel_mc  = '0;
    rl_sel_irc = '0;
    for (int v = 0; v < num_vcs; v++) begin
      if (flit_sel_ivc_in[v]) begin
        rl_sel_mc[v / (num_vcs_per_class * num_resource_classes)] = 1'b1;
        rl_sel_irc[(v / num_vcs_per_class) % num_resource_classes] = 1'b1;
      end
    end
  end

  for (genvar v = 0; v < num_vcs; v++) begin : g_vc
    logic                            arrive;
    logic                            dep;
    logic                            pop;
    logic                            push;
    logic                            err_head;
    logic                            err_body;
    logic                            err_dep;
    logic                            tail_close;
    logic [1:0]                      cnt_q;
    logic [1:0]                      cnt_mid;
    logic                            open_q;
    logic                            err_q;
    logic [num_ports-1:0]            op_q  [2];
    logic [num_resource_classes-1:0] orc_q [2];

    assign arrive     = flit_valid_in & flit_sel_ivc_in[v];
    assign dep        = flit_dep_ivc[v];
    assign pop        = dep & flit_dep_tail & (cnt_q != 2'd0);
    assign err_dep    = dep & (cnt_q == 2'd0);
    // A full queue still accepts a head when the front packet leaves this cycle.
    assign err_head   = arrive & flit_head_in & (open_q | ((cnt_q == 2'd2) & ~pop));
    assign push       = arrive & flit_head_in & ~err_head;
    assign err_body   = arrive & ~flit_head_in & ~open_q;
    assign tail_close = arrive & ~flit_head_in & flit_tail_in & open_q;
    assign cnt_mid    = cnt_q - {1'b0, pop};

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q    <= 2'd0;
        open_q   <= 1'b0;
        err_q    <= 1'b0;
        op_q[0]  <= '0;
        op_q[1]  <= '0;
        orc_q[0] <= '0;
        orc_q[1] <= '0;
      end else begin
        err_q <= err_head | err_body | err_dep;
        cnt_q <= cnt_mid + {1'b0, push};
        if (push)
          open_q <= ~flit_tail_in;
        else if (tail_close)
          open_q <= 1'b0;
        if (pop) begin
          op_q[0]  <= op_q[1];
          orc_q[0] <= orc_q[1];
          op_q[1]  <= '0;
          orc_q[1] <= '0;
        end
        // Push lands after the pop shift, so later assignments override it.
        if (push) begin
          if (cnt_mid == 2'd0) begin
            op_q[0]  <= rl_route_op;
            orc_q[0] <= rl_route_orc;
          end else begin
            op_q[1]  <= rl_route_op;
            orc_q[1] <= rl_route_orc;
          end
        end
      end
    end

    assign route_valid_ivc[v] = (cnt_q != 2'd0);
    assign route_ivc_op[v*num_ports +: num_ports] =
      (cnt_q != 2'd0) ? op_q[0] : '0;
    assign route_ivc_orc[v*num_resource_classes +: num_resource_classes] =
      (cnt_q != 2'd0) ? orc_q[0] : '0;
    assign error_ivc[v] = err_q;
  end

endmodule

// File: tb/tb_rtr_route_queue.sv
// Directed, table-driven bench for rtr_route_queue (4 VCs, 5 ports, 2 rcs).
module tb_rtr_route_queue;

  logic        clk;
  logic        reset;
  logic        flit_valid_in;
  logic        flit_head_in;
  logic        flit_tail_in;
  logic [3:0]  flit_sel_ivc_in;
  logic [7:0]  flit_dest_info_in;
  logic [7:0]  rl_dest_info;
  logic [1:0]  rl_sel_mc;
  logic [1:0]  rl_sel_irc;
  logic [4:0]  rl_route_op;
  logic [1:0]  rl_route_orc;
  logic [3:0]  flit_dep_ivc;
  logic        flit_dep_tail;
  logic [3:0]  route_valid_ivc;
  logic [19:0] route_ivc_op;
  logic [7:0]  route_ivc_orc;
  logic [3:0]  error_ivc;

  int checks = 0;
  int errors = 0;

  rtr_route_queue dut (
    .clk               (clk),
    .reset             (reset),
    .flit_valid_in     (flit_valid_in),
    .flit_head_in      (flit_head_in),
    .flit_tail_in      (flit_tail_in),
    .flit_sel_ivc_in   (flit_sel_ivc_in),
    .flit_dest_info_in (flit_dest_info_in),
    .rl_dest_info      (rl_dest_info),
    .rl_sel_mc         (rl_sel_mc),
    .rl_sel_irc        (rl_sel_irc),
    .rl_route_op       (rl_route_op),
    .rl_route_orc      (rl_route_orc),
    .flit_dep_ivc      (flit_dep_ivc),
    .flit_dep_tail     (flit_dep_tail),
    .route_valid_ivc   (route_valid_ivc),
    .route_ivc_op      (route_ivc_op),
    .route_ivc_orc     (route_ivc_orc),
    .error_ivc         (error_ivc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        valid;
    logic        head;
    logic        tail;
    logic [3:0]  sel;
    logic [7:0]  dest;
    logic [4:0]  op;
    logic [1:0]  orc;
    logic [3:0]  dep;
    logic        dep_tail;
    logic [1:0]  exp_mc;
    logic [1:0]  exp_irc;
    logic [3:0]  exp_valid;
    logic [19:0] exp_op;
    logic [7:0]  exp_orc;
    logic [3:0]  exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic drive_idle();
    flit_valid_in     = 1'b0;
    flit_head_in      = 1'b0;
    flit_tail_in      = 1'b0;
    flit_sel_ivc_in   = 4'b0000;
    flit_dest_info_in = 8'h00;
    rl_route_op       = 5'b00000;
    rl_route_orc      = 2'b00;
    flit_dep_ivc      = 4'b0000;
    flit_dep_tail     = 1'b0;
  endtask

  task automatic check_regs(input string tag, input logic [3:0] ev,
                            input logic [19:0] eop, input logic [7:0] eorc,
                            input logic [3:0] eerr);
    check_output({tag, " valid"}, {28'd0, route_valid_ivc}, {28'd0, ev});
    check_output({tag, " op"},    {12'd0, route_ivc_op},    {12'd0, eop});
    check_output({tag, " orc"},   {24'd0, route_ivc_orc},   {24'd0, eorc});
    check_output({tag, " err"},   {28'd0, error_ivc},       {28'd0, eerr});
  endtask

  // One vector: drive at negedge, check rl_* combinationally, check state after posedge.
  task automatic apply_stimulus(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    flit_valid_in     = v.valid;
    flit_head_in      = v.head;
    flit_tail_in      = v.tail;
    flit_sel_ivc_in   = v.sel;
    flit_dest_info_in = v.dest;
    rl_route_op       = v.op;
    rl_route_orc      = v.orc;
    flit_dep_ivc      = v.dep;
    flit_dep_tail     = v.dep_tail;
    #1;
    check_output({tag, " rl_sel_mc"},  {30'd0, rl_sel_mc},  {30'd0, v.exp_mc});
    check_output({tag, " rl_sel_irc"}, {30'd0, rl_sel_irc}, {30'd0, v.exp_irc});
    check_output({tag, " rl_dest"},    {24'd0, rl_dest_info}, {24'd0, v.dest});
    @(posedge clk);
    #1;
    check_regs(tag, v.exp_valid, v.exp_op, v.exp_orc, v.exp_err);
  endtask

  localparam logic [4:0] Z = 5'b00000;

  initial begin
    //             vld hd tl sel      dest   op        orc    dep      dt   mc     irc    e_valid  e_op                                  e_orc                        e_err
    vecs.push_back('{1, 1, 1, 4'b0100, 8'hA5, 5'b00100, 2'b01, 4'b0000, 0, 2'b10, 2'b01, 4'b0100, {Z, 5'b00100, Z, Z},        {2'b00, 2'b01, 2'b00, 2'b00}, 4'b0000});
    vecs.push_back('{0, 0, 0, 4'b0000, 8'h00, 5'b00000, 2'b00, 4'b0100, 1, 2'b00, 2'b00, 4'b0000, 20'd0,                       8'd0,                         4'b0000});
    vecs.push_back('{1, 1, 0, 4'b0001, 8'h11, 5'b10000, 2'b10, 4'b0000, 0, 2'b01, 2'b01, 4'b0001, {Z, Z, Z, 5'b10000},        {2'b00, 2'b00, 2'b00, 2'b10}, 4'b0000});
    vecs.push_back('{1, 0, 0, 4'b0001, 8'h22, 5'b11111, 2'b11, 4'b0000, 0, 2'b01, 2'b01, 4'b0001, {Z, Z, Z, 5'b10000},        {2'b00, 2'b00, 2'b00, 2'b10}, 4'b0000});
    vecs.push_back('{1, 0, 1, 4'b0001, 8'h33, 5'b11111, 2'b11, 4'b0000, 0, 2'b01, 2'b01, 4'b0001, {Z, Z, Z, 5'b10000},        {2'b00, 2'b00, 2'b00, 2'b10}, 4'b0000});
    vecs.push_back('{1, 1, 0, 4'b0001, 8'h44, 5'b00001, 2'b01, 4'b0000, 0, 2'b01, 2'b01, 4'b0001, {Z, Z, Z, 5'b10000},        {2'b00, 2'b00, 2'b00, 2'b10}, 4'b0000});
    vecs.push_back('{1, 0, 0, 4'b0001, 8'h45, 5'b11111, 2'b11, 4'b0000, 0, 2'b01, 2'b01, 4'b0001, {Z, Z, Z, 5'b10000},        {2'b00, 2'b00, 2'b00, 2'b10}, 4'b0000});
    vecs.push_back('{1, 0, 1, 4'b0001, 8'h46, 5'b11111, 2'b11, 4'b0000, 0, 2'b01, 2'b01, 4'b0001, {Z, Z, Z, 5'b10000},        {2'b00, 2'b00, 2'b00, 2'b10}, 4'b0000});
    vecs.push_back('{1, 1, 0, 4'b0001, 8'h55, 5'b01000, 2'b10, 4'b0000, 0, 2'b01, 2'b01, 4'b0001, {Z, Z, Z, 5'b10000},        {2'b00, 2'b00, 2'b00, 2'b10}, 4'b0001});
    vecs.push_back('{0, 0, 0, 4'b0000, 8'h00, 5'b00000, 2'b00, 4'b0000, 0, 2'b00, 2'b00, 4'b0001, {Z, Z, Z, 5'b10000},        {2'b00, 2'b00, 2'b00, 2'b10}, 4'b0000});
    vecs.push_back('{0, 0, 0, 4'b0000, 8'h00, 5'b00000, 2'b00, 4'b0001, 0, 2'b00, 2'b00, 4'b0001, {Z, Z, Z, 5'b10000},        {2'b00, 2'b00, 2'b00, 2'b10}, 4'b0000});
    vecs.push_back('{0, 0, 0, 4'b0000, 8'h00, 5'b00000, 2'b00, 4'b0001, 1, 2'b00, 2'b00, 4'b0001, {Z, Z, Z, 5'b00001},        {2'b00, 2'b00, 2'b00, 2'b01}, 4'b0000});
    vecs.push_back('{0, 0, 0, 4'b0000, 8'h00, 5'b00000, 2'b00, 4'b0001, 1, 2'b00, 2'b00, 4'b0000, 20'd0,                       8'd0,                         4'b0000});
    vecs.push_back('{0, 0, 0, 4'b0000, 8'h00, 5'b00000, 2'b00, 4'b0001, 1, 2'b00, 2'b00, 4'b0000, 20'd0,                       8'd0,                         4'b0001});
    vecs.push_back('{1, 1, 1, 4'b0010, 8'h66, 5'b01000, 2'b01, 4'b0000, 0, 2'b01, 2'b10, 4'b0010, {Z, Z, 5'b01000, Z},        {2'b00, 2'b00, 2'b01, 2'b00}, 4'b0000});
    vecs.push_back('{1, 1, 1, 4'b0010, 8'h77, 5'b00010, 2'b10, 4'b0000, 0, 2'b01, 2'b10, 4'b0010, {Z, Z, 5'b01000, Z},        {2'b00, 2'b00, 2'b01, 2'b00}, 4'b0000});
    vecs.push_back('{1, 1, 1, 4'b0010, 8'h88, 5'b10000, 2'b01, 4'b0010, 1, 2'b01, 2'b10, 4'b0010, {Z, Z, 5'b00010, Z},        {2'b00, 2'b00, 2'b10, 2'b00}, 4'b0000});
    vecs.push_back('{0, 0, 0, 4'b0000, 8'h00, 5'b00000, 2'b00, 4'b0010, 1, 2'b00, 2'b00, 4'b0010, {Z, Z, 5'b10000, Z},        {2'b00, 2'b00, 2'b01, 2'b00}, 4'b0000});
    vecs.push_back('{0, 0, 0, 4'b0000, 8'h00, 5'b00000, 2'b00, 4'b0010, 1, 2'b00, 2'b00, 4'b0000, 20'd0,                       8'd0,                         4'b0000});
    vecs.push_back('{1, 1, 1, 4'b0100, 8'h99, 5'b00001, 2'b01, 4'b0000, 0, 2'b10, 2'b01, 4'b0100, {Z, 5'b00001, Z, Z},        {2'b00, 2'b01, 2'b00, 2'b00}, 4'b0000});
    vecs.push_back('{1, 1, 1, 4'b0100, 8'hAA, 5'b01000, 2'b10, 4'b0100, 1, 2'b10, 2'b01, 4'b0100, {Z, 5'b01000, Z, Z},        {2'b00, 2'b10, 2'b00, 2'b00}, 4'b0000});
    vecs.push_back('{0, 0, 0, 4'b0000, 8'h00, 5'b00000, 2'b00, 4'b0100, 1, 2'b00, 2'b00, 4'b0000, 20'd0,                       8'd0,                         4'b0000});
    vecs.push_back('{1, 0, 0, 4'b1000, 8'hBB, 5'b11111, 2'b11, 4'b0000, 0, 2'b10, 2'b10, 4'b0000, 20'd0,                       8'd0,                         4'b1000});
    vecs.push_back('{1, 1, 0, 4'b1000, 8'h3C, 5'b00010, 2'b10, 4'b0000, 0, 2'b10, 2'b10, 4'b1000, {5'b00010, Z, Z, Z},        {2'b10, 2'b00, 2'b00, 2'b00}, 4'b0000});
    vecs.push_back('{1, 1, 0, 4'b1000, 8'h3D, 5'b00100, 2'b01, 4'b0000, 0, 2'b10, 2'b10, 4'b1000, {5'b00010, Z, Z, Z},        {2'b10, 2'b00, 2'b00, 2'b00}, 4'b1000});

    // Reset held with traffic on the inputs: everything must read zero.
    reset = 1'b0;
    drive_idle();
    flit_valid_in   = 1'b1;
    flit_head_in    = 1'b1;
    flit_sel_ivc_in = 4'b0001;
    rl_route_op     = 5'b10000;
    rl_route_orc    = 2'b01;
    repeat (2) @(negedge clk);
    check_regs("in_reset", 4'b0000, 20'd0, 8'd0, 4'b0000);
    drive_idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_regs("post_reset", 4'b0000, 20'd0, 8'd0, 4'b0000);

    for (int i = 0; i < vecs.size(); i++)
      apply_stimulus(i, vecs[i]);

    // Error pulse lasts one cycle; VC3 packet stays open.
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    check_regs("err_clear", 4'b1000, {5'b00010, Z, Z, Z}, {2'b10, 2'b00, 2'b00, 2'b00}, 4'b0000);

    // Asynchronous reset in mid-cycle while VC3 is mid-packet.
    #2;
    reset = 1'b0;
    #1;
    check_regs("async_reset", 4'b0000, 20'd0, 8'd0, 4'b0000);
    @(negedge clk);
    reset = 1'b1;

    // Tail after reset finds no open packet: error, nothing queued.
    @(negedge clk);
    flit_valid_in   = 1'b1;
    flit_tail_in    = 1'b1;
    flit_sel_ivc_in = 4'b1000;
    @(posedge clk);
    #1;
    check_regs("body_after_reset", 4'b0000, 20'd0, 8'd0, 4'b1000);
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    check_regs("final_idle", 4'b0000, 20'd0, 8'd0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
